bias_loader: RTL and testbench
==============================

Name: bias_loader

Overview:
Writable counterpart of the constant bias register file. Accepts a stream of 32-bit bias words over a valid/ready handshake and writes them into a 128 x 32 bias bank at sequential addresses starting from a programmable base. Exposes the same four asynchronous read ports and the same 128-bit packed bias output, so downstream MAC lanes can consume freshly loaded biases instead of constants.

Parameters:
DEPTH, 128, number of 32-bit bias entries (power of two).
AW, 7, address width, log2(DEPTH).
DW, 32, bias word width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle load request; sampled only in IDLE
base_addr  in  AW  first write address, captured on accepted start
count  in  AW+1  number of words to load, 1..DEPTH; 0 is illegal
abort  in  1  terminates an in-progress load
s_valid  in  1  stream word valid
s_data  in  DW  stream bias word
s_ready  out  1  loader accepts a word this cycle
busy  out  1  high in LOAD and DONE
done  out  1  one-cycle pulse when the final word has been written
err  out  1  one-cycle pulse: start with count==0
a1, a2, a3, a4  in  AW  read addresses
bias  out  4*DW  {mem[a4], mem[a3], mem[a2], mem[a1]}; mem[a1] in bits [31:0]

Behaviour:
- Reset (async, rst_n low): state=IDLE, s_ready=0, busy=0, done=0, err=0, write address=0, remaining=0. Bank contents are not reset; unwritten entries read as don't-care. Deasserting rst_n mid-load leaves entries already written intact.
- States: IDLE, LOAD, DONE.
- IDLE: s_ready=0. start && count!=0 -> LOAD; waddr<=base_addr, remaining<=count. start && count==0 -> remain in IDLE, err=1 on the next cycle only (registered). start in LOAD/DONE is ignored.
- LOAD: s_ready = !abort (combinational). Handshake = s_valid && s_ready. On handshake: mem[waddr]<=s_data, waddr<=waddr+1 mod DEPTH (127 wraps to 0), remaining<=remaining-1. Handshake with remaining==1 -> DONE. abort -> IDLE with no write in that cycle and no done pulse; words already written remain. s_valid low stalls indefinitely with no timeout.
- DONE: exactly one cycle; done=1 (registered output high during DONE), s_ready=0, busy=1; -> IDLE. A new start is accepted on the first IDLE cycle, so minimum spacing between back-to-back loads is 1 idle cycle.
- Throughput: one word per cycle while s_valid stays high. A load of N words with s_valid constant takes N LOAD cycles plus 1 DONE cycle.
- Reads: combinational, identical packing to the constant regfile. Read-during-write to the same address returns the old value; the new word is visible from the cycle after its handshake. All four ports may address the same entry.
- count==DEPTH with any base overwrites every entry exactly once (wrap-around).

Test Plan:
- Reset then start, base=0, count=4, stream 0x00000082, 0xFFFFFA8C, 0xFFFFFE90, 0xFFFFFF81 with s_valid held -> s_ready for 4 cycles, done pulses in cycle 5; a1..a4=0,1,2,3 give bias=0xFFFFFF81_FFFFFE90_FFFFFA8C_00000082.
- base=126, count=4, data 0x11,0x22,0x33,0x44 -> mem[126]=0x11, mem[127]=0x22, mem[0]=0x33, mem[1]=0x44; done after the 4th beat.
- Count=3 with s_valid toggling 1,0,0,1,1 -> exactly 3 writes at base..base+2, done one cycle after the 3rd handshake; no write while s_valid=0.
- Abort after 2 of 5 words, with s_valid high on the abort cycle -> s_ready=0 that cycle, no third write, no done, IDLE next cycle; the 2 written entries keep their new values.
- start with count=0 -> err pulses for one cycle, busy stays 0, s_ready stays 0; start asserted during LOAD -> ignored, base/count unchanged.
- Read address equal to write address during handshake (a1=5, write 0xDEADBEEF to 5) -> bias[31:0] holds the old value that cycle and 0xDEADBEEF the next; rst_n pulsed low mid-load -> IDLE immediately, outputs 0, earlier writes retained.

Source files
------------

// File: rtl/bias_loader.sv
// Streaming bias bank loader: accepted words land at sequential (wrapping) addresses from a base.
// Latency: a word is readable the cycle after its handshake; an N-word load is busy for N+1 cycles.
// Backpressure: s_ready only in LOAD, dropped combinationally by abort; s_valid gaps stall indefinitely.
module bias_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    input  logic [AW-1:0] a3,
    input  logic [AW-1:0] a4,
    output logic [4*DW-1:0] bias
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] waddr;
    logic [AW:0]   remaining;
    logic          go;
    logic          err_nxt;
    logic          hs;
    logic [DW-1:0] mem [DEPTH];

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        go        = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        go        = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                // abort wins over a coincident beat: nothing is written that cycle
                s_ready = !abort;
                if (abort)
                    state_nxt = IDLE;
                else if (s_valid && remaining == (AW+1)'(1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign hs   = s_valid && s_ready;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            err       <= 1'b0;
            waddr     <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
            if (go) begin
                waddr     <= base_addr;
                remaining <= count;
            end else if (hs) begin
                // DEPTH is a power of two, so the address wraps naturally
                waddr     <= waddr + AW'(1);
                remaining <= remaining - (AW+1)'(1);
            end
        end
    end

    // Bank is deliberately unreset so a mid-load reset keeps already-written entries
    always_ff @(posedge clk) begin
        if (hs)
            mem[waddr] <= s_data;
    end

    assign bias = {mem[a4], mem[a3], mem[a2], mem[a1]};

endmodule

// File: tb/tb_bias_loader.sv
// Bench for bias_loader: per-cycle vector table, hand-written corner sequences, randomized loads vs. bank model.
module tb_bias_loader;

    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          abort;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready, busy, done, err;
    logic [AW-1:0] a1, a2, a3, a4;
    logic [4*DW-1:0] bias;

    bias_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .busy(busy), .done(done), .err(err),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .bias(bias)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] load_q [$];

    typedef struct {
        logic          st;
        logic [AW-1:0] ba;
        logic [AW:0]   cn;
        logic          ab;
        logic          sv;
        logic [DW-1:0] sd;
        logic [3:0]    exp;   // {s_ready, busy, done, err}
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic st, input int ba, input int cn, input logic ab,
                                input logic sv, input logic [DW-1:0] sd, input logic [3:0] exp);
        vec_t v;
        v.st = st; v.ba = AW'(ba); v.cn = (AW+1)'(cn); v.ab = ab; v.sv = sv; v.sd = sd; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string name, input int x1, input int x2, input int x3, input int x4);
        a1 = AW'(x1); a2 = AW'(x2); a3 = AW'(x3); a4 = AW'(x4);
        @(negedge clk);
        chk(name, bias, {mdl[x4], mdl[x3], mdl[x2], mdl[x1]});
        next_cycle();
    endtask

    // Loads load_q starting at base; s_valid drops with probability gap_pct percent.
    task automatic run_load(input int base, input int gap_pct);
        int n;
        int k;
        int cyc;
        n   = load_q.size();
        k   = 0;
        cyc = 0;
        start = 1'b1; base_addr = AW'(base); count = (AW+1)'(n); s_valid = 1'b0;
        @(negedge clk);
        chk("ld_start_busy", busy, 1'b0);
        next_cycle();
        start = 1'b0;
        while (k < n && cyc < 2000) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? load_q[k] : $urandom;
            @(negedge clk);
            chk("ld_ready", s_ready, 1'b1);
            chk("ld_done_early", done, 1'b0);
            if (s_valid) begin
                mdl[(base + k) % DEPTH] = load_q[k];
                k++;
            end
            next_cycle();
            cyc++;
        end
        chk("ld_timeout", k, n);
        s_valid = 1'b1; s_data = $urandom;
        @(negedge clk);
        chk("ld_done", {s_ready, busy, done}, 3'b011);
        next_cycle();
        s_valid = 1'b0;
        @(negedge clk);
        chk("ld_idle", {s_ready, busy, done}, 3'b000);
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;

        #12;
        chk("reset_outs", {s_ready, busy, done, err}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Full-bank load from an odd base: every entry written once, with wrap
        load_q.delete();
        for (int k = 0; k < DEPTH; k++) load_q.push_back(32'h5A00_0000 | 32'((77 + k) % DEPTH));
        run_load(77, 0);
        for (int i = 0; i < DEPTH / 4; i++)
            read_chk("full_bank", 4*i, 4*i+1, 4*i+2, 4*i+3);

        tbl[0]  = mk(1, 0, 4, 0, 0, 32'h0, 4'b0000);
        tbl[1]  = mk(0, 0, 0, 0, 1, 32'h0000_0082, 4'b1100);
        tbl[2]  = mk(0, 0, 0, 0, 1, 32'hFFFF_FA8C, 4'b1100);
        tbl[3]  = mk(0, 0, 0, 0, 1, 32'hFFFF_FE90, 4'b1100);
        tbl[4]  = mk(0, 0, 0, 0, 1, 32'hFFFF_FF81, 4'b1100);
        tbl[5]  = mk(0, 0, 0, 0, 0, 32'h0, 4'b0110);
        tbl[6]  = mk(1, 9, 0, 0, 0, 32'h0, 4'b0000);
        tbl[7]  = mk(0, 0, 0, 0, 0, 32'h0, 4'b0001);
        tbl[8]  = mk(1, 10, 3, 0, 0, 32'h0, 4'b0000);
        tbl[9]  = mk(0, 0, 0, 0, 1, 32'hA1A1_A1A1, 4'b1100);
        tbl[10] = mk(1, 50, 7, 0, 0, 32'h0, 4'b1100);
        tbl[11] = mk(0, 0, 0, 0, 0, 32'h0, 4'b1100);
        tbl[12] = mk(0, 0, 0, 0, 1, 32'hA2A2_A2A2, 4'b1100);
        tbl[13] = mk(0, 0, 0, 0, 1, 32'hA3A3_A3A3, 4'b1100);
        tbl[14] = mk(0, 0, 0, 0, 0, 32'h0, 4'b0110);
        tbl[15] = mk(0, 0, 0, 0, 0, 32'h0, 4'b0000);
        tbl[16] = mk(1, 20, 5, 0, 0, 32'h0, 4'b0000);
        tbl[17] = mk(0, 0, 0, 0, 1, 32'hB1B1_B1B1, 4'b1100);
        tbl[18] = mk(0, 0, 0, 0, 1, 32'hB2B2_B2B2, 4'b1100);
        tbl[19] = mk(0, 0, 0, 1, 1, 32'hB3B3_B3B3, 4'b0100);
        tbl[20] = mk(0, 0, 0, 0, 1, 32'hBAD0_BAD0, 4'b0000);
        tbl[21] = mk(0, 0, 0, 0, 0, 32'h0, 4'b0000);

        for (int r = 0; r < 22; r++) begin
            start = tbl[r].st; base_addr = tbl[r].ba; count = tbl[r].cn;
            abort = tbl[r].ab; s_valid = tbl[r].sv; s_data = tbl[r].sd;
            @(negedge clk);
            chk($sformatf("vec%0d", r), {s_ready, busy, done, err}, tbl[r].exp);
            next_cycle();
        end
        start = 1'b0; abort = 1'b0; s_valid = 1'b0;

        a1 = 7'd0; a2 = 7'd1; a3 = 7'd2; a4 = 7'd3;
        @(negedge clk);
        chk("first_load_bias", bias, 128'hFFFFFF81_FFFFFE90_FFFFFA8C_00000082);
        next_cycle();
        mdl[0] = 32'h0000_0082; mdl[1] = 32'hFFFF_FA8C; mdl[2] = 32'hFFFF_FE90; mdl[3] = 32'hFFFF_FF81;
        mdl[10] = 32'hA1A1_A1A1; mdl[11] = 32'hA2A2_A2A2; mdl[12] = 32'hA3A3_A3A3;
        mdl[20] = 32'hB1B1_B1B1; mdl[21] = 32'hB2B2_B2B2;
        read_chk("stall_load", 10, 11, 12, 13);
        read_chk("abort_kept", 20, 21, 22, 50);

        // Wrap from the top of the bank
        load_q.delete();
        load_q.push_back(32'h11); load_q.push_back(32'h22); load_q.push_back(32'h33); load_q.push_back(32'h44);
        run_load(126, 0);
        a1 = 7'd126; a2 = 7'd127; a3 = 7'd0; a4 = 7'd1;
        @(negedge clk);
        chk("wrap_bias", bias, {32'h44, 32'h33, 32'h22, 32'h11});
        next_cycle();

        // Read-during-write returns the old word, the new one the next cycle
        a1 = 7'd5; a2 = 7'd5; a3 = 7'd5; a4 = 7'd5;
        start = 1'b1; base_addr = 7'd5; count = 8'd1;
        next_cycle();
        start = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rdw_old", bias, {4{mdl[5]}});
        next_cycle();
        s_valid = 1'b0;
        @(negedge clk);
        chk("rdw_new", bias, {4{32'hDEAD_BEEF}});
        chk("rdw_done", done, 1'b1);
        next_cycle();
        mdl[5] = 32'hDEAD_BEEF;

        // Reset mid-load: immediate IDLE, earlier writes retained
        start = 1'b1; base_addr = 7'd40; count = 8'd4;
        next_cycle();
        start = 1'b0; s_valid = 1'b1; s_data = 32'hC1C1_C1C1;
        next_cycle();
        s_data = 32'hC2C2_C2C2;
        next_cycle();
        mdl[40] = 32'hC1C1_C1C1; mdl[41] = 32'hC2C2_C2C2;
        s_data = 32'hC3C3_C3C3; rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {s_ready, busy, done, err}, 4'b0000);
        next_cycle();
        s_valid = 1'b0; rst_n = 1'b1;
        next_cycle();
        read_chk("midrst_kept", 40, 41, 42, 43);

        // Randomized loads against the bank model
        for (int t = 0; t < 8; t++) begin
            int b;
            int n;
            b = $urandom_range(DEPTH - 1);
            n = $urandom_range(48, 1);
            load_q.delete();
            for (int k = 0; k < n; k++) load_q.push_back($urandom);
            run_load(b, 35);
            for (int j = 0; j < 4; j++)
                read_chk("rand_read", $urandom_range(DEPTH - 1), (b + j) % DEPTH,
                         (b + n - 1) % DEPTH, $urandom_range(DEPTH - 1));
        end
        for (int i = 0; i < DEPTH / 4; i++)
            read_chk("final_sweep", i, i + 32, i + 64, i + 96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
